// File: rtl/m23xx1024_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m23xx1024_mem_arbiter
// Purpose  : Two-port arbiter sharing one M23XX1024 serial SRAM controller
//            between the 8051 external-memory bridge (port 0) and the Si3000
//            audio sample DMA (port 1). Audio has fixed priority, bounded by a
//            starvation limit. A watchdog aborts transactions whose done
//            never arrives.
// Ports    : clk, reset (async, active-high)
//            req0/1, we0/1, addr0/1[16:0], wdata0/1[7:0]  - requester inputs
//            ack0/1, err, rdata[7:0]                       - requester outputs
//            mem_start, mem_we, mem_addr, mem_wdata, mem_abort - to controller
//            mem_done, mem_rdata                           - from controller
//            busy, grant[1:0]                              - status
// Revision : 1.0 - initial release
// ============================================================================
module m23xx1024_mem_arbiter #(
  parameter int MAX_CONSEC     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [16:0] addr0,
  input  logic [16:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        mem_start,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_done,
  input  logic [7:0]  mem_rdata,
  output logic        mem_abort,
  output logic        busy,
  output logic [1:0]  grant
);

  // Starvation counter is at least 3 bits wide, wider if the limit needs it.
  localparam int CNT_W = ($clog2(MAX_CONSEC + 1) > 3) ? $clog2(MAX_CONSEC + 1) : 3;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CONSEC_LIMIT = CNT_W'(MAX_CONSEC);
  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] consec_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             timed_out;
  logic             pick1;

  // Port 1 wins unless port 0 is waiting and audio has used up its run.
  always_comb begin
    pick1 = req1 && !(req0 && (consec_cnt == CONSEC_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      consec_cnt <= '0;
      tmo_cnt    <= '0;
      timed_out  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 8'h00;
      mem_start  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 17'h0;
      mem_wdata  <= 8'h00;
      mem_abort  <= 1'b0;
      busy       <= 1'b0;
      grant      <= 2'b00;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      mem_start <= 1'b0;
      mem_abort <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            if (pick1) begin
              grant     <= 2'b10;
              mem_we    <= we1;
              mem_addr  <= addr1;
              mem_wdata <= wdata1;
              if (req0) begin
                if (consec_cnt != {CNT_W{1'b1}}) begin
                  consec_cnt <= consec_cnt + 1'b1;
                end
              end else begin
                consec_cnt <= '0;
              end
            end else begin
              grant      <= 2'b01;
              mem_we     <= we0;
              mem_addr   <= addr0;
              mem_wdata  <= wdata0;
              consec_cnt <= '0;
            end
            mem_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          tmo_cnt   <= '0;
          timed_out <= 1'b0;
          state     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (timed_out) begin
            // Abort pulse has been issued in the previous cycle; report now.
            ack0      <= grant[0];
            ack1      <= grant[1];
            err       <= 1'b1;
            rdata     <= 8'hFF;
            timed_out <= 1'b0;
            state     <= ST_ACK;
          end else if (mem_done) begin
            // Done takes precedence over a coincident expiry.
            ack0  <= grant[0];
            ack1  <= grant[1];
            err   <= 1'b0;
            rdata <= mem_rdata;
            state <= ST_ACK;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_abort <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_ACK: begin
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m23xx1024_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m23xx1024_mem_arbiter
// Purpose  : Self-checking bench for m23xx1024_mem_arbiter with a behavioural
//            SRAM controller model and an expected-ack scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_m23xx1024_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [16:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, err;
  logic [7:0]  rdata;
  logic        mem_start, mem_we, mem_abort, busy;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_done = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  grant;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       port;
    logic       err;
    logic       chk_data;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  m23xx1024_mem_arbiter #(
    .MAX_CONSEC     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .err       (err),
    .rdata     (rdata),
    .mem_start (mem_start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .mem_abort (mem_abort),
    .busy      (busy),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic e, input logic cd, input logic [7:0] d);
    exp_t x;
    x.port = port; x.err = e; x.chk_data = cd; x.data = d;
    sb.push_back(x);
  endtask

  // SRAM controller model: done arrives done_dly cycles after the start
  // cycle (0 = never). Unwritten locations read back as 8'hC3.
  logic [7:0] sram [int];
  int done_dly = 2;
  int cd = -1;
  always @(negedge clk) begin
    mem_done = 1'b0;
    if (reset || mem_abort) begin
      cd = -1;
    end else if (mem_start) begin
      cd = done_dly;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_done = 1'b1;
        if (mem_we) sram[int'(mem_addr)] = mem_wdata;
        mem_rdata = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 8'hC3;
        cd = -1;
      end
    end
  end

  // Scoreboard: every ack pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (ack0 || ack1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {ack1, ack0}, 32'h0);
      end else begin
        cur = sb.pop_front();
        chk("ack_port", {ack1, ack0}, cur.port ? 32'h2 : 32'h1);
        chk("ack_grant", grant, cur.port ? 32'h2 : 32'h1);
        chk("ack_err", err, cur.err);
        if (cur.chk_data) chk("ack_rdata", rdata, cur.data);
      end
    end
  end

  task automatic wait_ack(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("ack_wait_timeout", 32'h0, 32'h1);
  endtask

  int t_start, t_abort, t_ack, n_abort;

  task automatic watch(input int maxc);
    t_start = -1; t_abort = -1; t_ack = -1; n_abort = 0;
    for (int c = 0; c < maxc && t_ack < 0; c++) begin
      @(negedge clk);
      if (mem_start) t_start = c;
      if (mem_abort) begin n_abort++; t_abort = c; end
      if (ack0 || ack1) t_ack = c;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_start", mem_start, 0);
    chk("rst_mem_abort", mem_abort, 0);
    chk("rst_mem_cmd", {mem_we, mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single write then read back
    done_dly = 2;
    req0 = 1'b1; we0 = 1'b1; addr0 = 17'h1ABCD; wdata0 = 8'h5A;
    push(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wr_mem_start", mem_start, 1);
    chk("wr_mem_addr", mem_addr, 32'h1ABCD);
    chk("wr_mem_wdata", mem_wdata, 32'h5A);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_grant", grant, 2'b01);
    chk("wr_busy", busy, 1);
    repeat (2) @(negedge clk);
    chk("wr_no_early_ack", ack0, 0);
    @(negedge clk);
    chk("wr_ack_latency", ack0, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    req0 = 1'b1; we0 = 1'b0;
    push(1'b0, 1'b0, 1'b1, 8'h5A);
    wait_ack(10);
    req0 = 1'b0;
    @(negedge clk);

    // Priority: port 1 first, then port 0
    done_dly = 1;
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 17'h00100;
    push(1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("prio_first_grant", grant, 2'b10);
    wait_ack(10);
    req1 = 1'b0;
    wait_ack(10);
    req0 = 1'b0;
    @(negedge clk);

    // Starvation limit: four audio grants, one CPU grant, audio resumes
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b0, 1'b0, 8'h00);
    push(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) wait_ack(10);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Timeout: controller never answers
    done_dly = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 17'h00200;
    push(1'b1, 1'b1, 1'b1, 8'hFF);
    watch(40);
    chk("tmo_abort_count", n_abort, 1);
    chk("tmo_abort_cycle", t_abort - t_start, 17);
    chk("tmo_ack_cycle", t_ack - t_start, 18);
    req1 = 1'b0;
    @(negedge clk);
    done_dly = 2;
    req1 = 1'b1; addr1 = 17'h1ABCD;
    push(1'b1, 1'b0, 1'b1, 8'h5A);
    wait_ack(10);
    req1 = 1'b0;
    @(negedge clk);

    // Done arriving exactly in the expiry cycle
    done_dly = 16;
    req0 = 1'b1; we0 = 1'b0; addr0 = 17'h1ABCD;
    push(1'b0, 1'b0, 1'b1, 8'h5A);
    watch(40);
    chk("tie_abort_count", n_abort, 0);
    chk("tie_ack_cycle", t_ack - t_start, 17);
    req0 = 1'b0;
    @(negedge clk);

    // Asynchronous reset in WAIT
    done_dly = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 17'h1ABCD;
    @(negedge clk);
    chk("rstw_started", mem_start, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_grant", grant, 0);
    chk("rstw_mem_cmd", {mem_start, mem_we, mem_addr, mem_wdata}, 0);
    chk("rstw_mem_abort", mem_abort, 0);
    chk("rstw_rdata", rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw_no_ack", {ack1, ack0, err}, 0);
    end
    done_dly = 2;
    reset = 1'b0;
    push(1'b0, 1'b0, 1'b1, 8'h5A);
    wait_ack(10);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m23xx1024_mem_arbiter.md
# m23xx1024_mem_arbiter

Two-port request arbiter that shares the single M23XX1024 serial SRAM controller between the 8051 external-memory bridge (port 0) and the Si3000 audio sample DMA (port 1). It serialises byte transactions onto the SRAM controller's start/done handshake. Audio has fixed priority, bounded by a starvation limit that guarantees the CPU a slot. A watchdog aborts any transaction whose `done` never arrives.

## Interface
Parameters:
- `MAX_CONSEC`, 4: maximum consecutive port-1 grants while port 0 is requesting.
- `TIMEOUT_CYCLES`, 1023: cycles spent in WAIT before an abort; must be ≥ 2.

Ports:
- `clk` input 1: system clock; one clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `req0`, `req1` input 1: transaction request, held high until the matching ack.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `addr0`, `addr1` input 17: byte address (128 KB).
- `wdata0`, `wdata1` input 8: write data.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `err` output 1: asserted together with the ack pulse when the transaction timed out.
- `rdata` output 8: read data, valid during the ack cycle and held until the next ack.
- `mem_start` output 1: one-cycle pulse to the SRAM controller.
- `mem_we`, `mem_addr[16:0]`, `mem_wdata[7:0]` outputs: registered command, stable from `mem_start` until `mem_done` or abort.
- `mem_done` input 1: controller completion pulse.
- `mem_rdata` input 8: controller read data, valid while `mem_done` is high.
- `mem_abort` output 1: one-cycle pulse telling the controller to drop CS and return to idle.
- `busy` output 1: high in every state except IDLE.
- `grant` output 2: one-hot owner of the current transaction; 00 in IDLE.

## Operation
- States: IDLE → ISSUE → WAIT → ACK → IDLE.
- IDLE: requests are sampled only here.
  - Only one request high: grant that port.
  - Both high: grant port 1, unless `consec_cnt` = `MAX_CONSEC`, in which case grant port 0.
  - On the grant edge, latch `we`/`addr`/`wdata` of the winner into the `mem_*` registers and go to ISSUE.
- `consec_cnt` (3+ bits, saturating):
  - Increments on a port-1 grant when `req0` was high at that grant.
  - Clears on any port-0 grant.
  - Clears on a port-1 grant when `req0` was low.
- ISSUE: `mem_start` = 1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Count cycles.
  - `mem_done` = 1: capture `mem_rdata` into `rdata` (writes capture it too; the value is don't-care to requesters). Clear `err`. Go to ACK.
  - Count reaches `TIMEOUT_CYCLES` without `mem_done`: pulse `mem_abort` for one cycle, set `rdata` = 8'hFF, set the error flag, go to ACK.
  - If `mem_done` and timeout occur in the same cycle, `mem_done` wins and no abort is issued.
- ACK: assert `ack` of the granted port and `err` (if flagged) for one cycle. `grant` is still valid. Go to IDLE.
- A requester that keeps `req` high after its ack issues a new transaction. That transaction is re-arbitrated in the following IDLE cycle.
- `mem_done` outside WAIT is ignored.
- Changes to `req`/`addr` of the non-granted port have no effect until IDLE.

## Timing
- Reset (asynchronous, immediate), including in mid-transaction:
  - State goes to IDLE.
  - All outputs go to 0: `ack*`, `err`, `rdata`, `mem_start`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_abort`, `busy`, `grant`.
  - `consec_cnt` goes to 0.
  - No abort pulse is generated by reset; the controller is reset by the same signal.
- Latency: request sampled at edge k, then:
  - `mem_start` is high during cycle k+1.
  - `mem_done` arrives at the earliest during cycle k+2.
  - `ack` is high during cycle k+3.
  - Minimum request-to-ack latency is 3 cycles plus controller latency.
- Throughput: one IDLE cycle between transactions, so the minimum issue period is 4 cycles plus controller latency.
- Timeout: `mem_abort` is high in the cycle after the `TIMEOUT_CYCLES`-th WAIT cycle, and `ack`/`err` follow in the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single write, then read:
  - Stimulus: `req0`, `we0`=1, `addr0`=17'h1ABCD, `wdata0`=8'h5A. The controller model returns `mem_done` 2 cycles after `mem_start`.
  - Required: `mem_start` 1 cycle after sampling with matching `mem_addr`/`mem_wdata`; `ack0` 3 cycles after `mem_start`.
  - Follow with a read of the same address: `rdata` = 8'h5A during `ack0`, `err` = 0.
- Priority:
  - Stimulus: `req0` and `req1` rise in the same cycle with `consec_cnt` = 0.
  - Required: `grant` = 10 first, then 01 on the next transaction.
- Starvation limit, `MAX_CONSEC` = 4:
  - Stimulus: `req1` held continuously and `req0` held.
  - Required: exactly 4 port-1 acks, then one port-0 ack, then port-1 grants resume.
- Timeout, `TIMEOUT_CYCLES` = 16:
  - Stimulus: the controller never returns `mem_done`.
  - Required: `mem_abort` pulses once; `ack1` and `err` are high together with `rdata` = 8'hFF; the next transaction completes with `err` = 0.
- Simultaneous done and timeout:
  - Stimulus: `mem_done` arrives exactly in the expiry cycle.
  - Required: no `mem_abort`, `err` = 0, real data returned.
- Reset mid-WAIT:
  - Stimulus: assert `reset` asynchronously (between clock edges) while in WAIT.
  - Required: `busy`, `grant`, and `mem_*` drop to 0 immediately; no ack is produced; after release, a pending `req0` is granted normally.
